picomips_io_ctrl: RTL and testbench

Switch/LED I/O sequencer for the picoMIPS board wrapper. Filters the SW8 handshake and captures SW7-0 operand words into a buffer, one per handshake cycle. It starts the CPU, collects result words, and presents them on LED one per handshake edge. It sits between the board pins and the picoMIPS core, so the core never touches raw switches.

---
 rtl/picomips_pkg.sv | 24 ++
 rtl/picomips_io_ctrl_if.sv | 22 ++
 rtl/picomips_hs_filter.sv | 97 +++++++++
 rtl/picomips_io_ctrl.sv | 158 +++++++++++++++
 tb/tb_picomips_io_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS board I/O sequencer.
package picomips_pkg;

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IN_HI = 3'd1,
        IN_LO = 3'd2,
        RUN   = 3'd3,
        SHOW  = 3'd4
    } io_state_t;

    localparam int PICOMIPS_DATA_W = 8;

    // Board switch bit positions
    localparam int SW_RESET_BIT = 9;
    localparam int SW_HS_BIT    = 8;
    localparam int SW_DATA_MSB  = 7;
    localparam int SW_DATA_LSB  = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/picomips_io_ctrl_if.sv
// Core-side bus between the I/O sequencer (master) and the picoMIPS core (slave).
interface picomips_io_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 1
);
    logic              cpu_run;
    logic              cpu_start;
    logic [SEL_W-1:0]  cpu_in_sel;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_out_we;
    logic [DATA_W-1:0] cpu_out_data;

    modport master (
        output cpu_run, cpu_start, cpu_in_data,
        input  cpu_in_sel, cpu_out_we, cpu_out_data
    );

    modport slave (
        input  cpu_run, cpu_start, cpu_in_data,
        output cpu_in_sel, cpu_out_we, cpu_out_data
    );
endinterface

// File: rtl/picomips_hs_filter.sv
// SW8 handshake synchroniser, edge detector and optional debouncer.
// Optional feature: define PICOMIPS_HS_DEBOUNCE_EN to enable the debounce counter.
module picomips_hs_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic hs_async_i,
    output logic hs_s_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

`ifdef PICOMIPS_HS_DEBOUNCE_EN
    localparam int READY_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int READY_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int RDY_W = $clog2(READY_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_s;
    logic                   hs_s;
    logic                   hs_d_q;
    logic [RDY_W-1:0]       ready_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= hs_async_i;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign raw_s = sync_q[SYNC_STAGES-1];

`ifdef PICOMIPS_HS_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_q;
    logic             db_level_q;

    // Level follows raw only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else if (raw_s != db_level_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q   <= '0;
                db_level_q <= raw_s;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign hs_s = db_level_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign hs_s = raw_s;
`endif

    // The filtered level is meaningless until the pipeline has refilled after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d_q      <= 1'b0;
            ready_cnt_q <= '0;
        end else begin
            hs_d_q <= hs_s;
            if (ready_cnt_q != RDY_W'(READY_CYCLES)) begin
                ready_cnt_q <= ready_cnt_q + 1'b1;
            end
        end
    end

    assign hs_s_o  = hs_s;
    assign rise_o  = hs_s & ~hs_d_q;
    assign fall_o  = ~hs_s & hs_d_q;
    assign ready_o = (ready_cnt_q == RDY_W'(READY_CYCLES));

endmodule

// File: rtl/picomips_io_ctrl.sv
// Switch/LED I/O sequencer: captures operands, runs the core, shows results on LED.
// Optional feature: PICOMIPS_HS_DEBOUNCE_EN (handshake debounce, see picomips_hs_filter).
module picomips_io_ctrl
    import picomips_pkg::*;
#(
    parameter int DATA_W          = PICOMIPS_DATA_W,
    parameter int N_IN            = 2,
    parameter int N_OUT           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_handshake,
    input  logic [DATA_W-1:0]    sw_data,
    picomips_io_ctrl_if.master   cpu,
    output logic [DATA_W-1:0]    led,
    output logic                 busy
);

    localparam int SEL_W = idx_w(N_IN);
    localparam int OI_W  = idx_w(N_OUT);

    io_state_t         state_q, state_d;
    logic [SEL_W-1:0]  ii_q, ii_d;
    logic [OI_W-1:0]   oi_q, oi_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              cpu_start_q;
    logic              in_we, out_we;

    logic [DATA_W-1:0] in_buf_q  [N_IN];
    logic [DATA_W-1:0] out_buf_q [N_OUT];

    logic hs_s, hs_rise, hs_fall, hs_ready;

    picomips_hs_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hs_filter (
        .clk        (clk),
        .reset      (reset),
        .hs_async_i (sw_handshake),
        .hs_s_o     (hs_s),
        .rise_o     (hs_rise),
        .fall_o     (hs_fall),
        .ready_o    (hs_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARM;
            ii_q        <= '0;
            oi_q        <= '0;
            led_q       <= '0;
            cpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ii_q        <= ii_d;
            oi_q        <= oi_d;
            led_q       <= led_d;
            cpu_start_q <= (state_d == RUN) && (state_q != RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        ii_d    = ii_q;
        oi_d    = oi_q;
        led_d   = led_q;
        in_we   = 1'b0;
        out_we  = 1'b0;
        case (state_q)
            ARM: begin
                // A switch held high through reset must first be seen low
                if (hs_ready && !hs_s) begin
                    state_d = IN_HI;
                end
            end
            IN_HI: begin
                if (hs_rise) begin
                    in_we   = 1'b1;
                    state_d = IN_LO;
                end
            end
            IN_LO: begin
                if (hs_fall) begin
                    if (ii_q == SEL_W'(N_IN - 1)) begin
                        ii_d    = '0;
                        state_d = RUN;
                    end else begin
                        ii_d    = ii_q + 1'b1;
                        state_d = IN_HI;
                    end
                end
            end
            RUN: begin
                if (cpu.cpu_out_we) begin
                    out_we = 1'b1;
                    if (oi_q == OI_W'(N_OUT - 1)) begin
                        oi_d    = '0;
                        state_d = SHOW;
                        // Word 0 is still being written when there is only one result
                        led_d   = (oi_q == '0) ? cpu.cpu_out_data : out_buf_q[0];
                    end else begin
                        oi_d = oi_q + 1'b1;
                    end
                end
            end
            SHOW: begin
                if (hs_rise || hs_fall) begin
                    if (32'(oi_q) < N_OUT - 1) begin
                        oi_d  = oi_q + 1'b1;
                        led_d = out_buf_q[oi_q + 1'b1];
                    end else begin
                        oi_d    = '0;
                        state_d = ARM;
                    end
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_buf
        always_ff @(posedge clk) begin
            if (reset) begin
                in_buf_q[gi] <= '0;
            end else if (in_we && (ii_q == SEL_W'(gi))) begin
                in_buf_q[gi] <= sw_data;
            end
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_buf
        always_ff @(posedge clk) begin
            if (reset) begin
                out_buf_q[gi] <= '0;
            end else if (out_we && (oi_q == OI_W'(gi))) begin
                out_buf_q[gi] <= cpu.cpu_out_data;
            end
        end
    end

    always_comb begin
        cpu.cpu_in_data = '0;
        if (32'(cpu.cpu_in_sel) < N_IN) begin
            cpu.cpu_in_data = in_buf_q[cpu.cpu_in_sel];
        end
    end

    assign cpu.cpu_run   = (state_q == RUN);
    assign cpu.cpu_start = cpu_start_q;
    assign led           = led_q;
    assign busy          = (state_q != IN_HI) && (state_q != ARM);

endmodule

// File: tb/tb_picomips_io_ctrl.sv
// Directed bench for picomips_io_ctrl; honours PICOMIPS_HS_DEBOUNCE_EN when defined.
module tb_picomips_io_ctrl;
    import picomips_pkg::*;

    localparam int SYNC = 2;
`ifdef PICOMIPS_HS_DEBOUNCE_EN
    localparam int DB  = 4;
    localparam int LAT = SYNC + 1 + DB;
`else
    localparam int DB  = 16;
    localparam int LAT = SYNC + 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_handshake;
    logic [7:0] sw_data;
    logic [7:0] led;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    picomips_io_ctrl_if #(.DATA_W(8), .SEL_W(1)) cpu_if ();

    picomips_io_ctrl #(
        .DATA_W          (8),
        .N_IN            (2),
        .N_OUT           (2),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_handshake (sw_handshake),
        .sw_data      (sw_data),
        .cpu          (cpu_if),
        .led          (led),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input io_state_t s, input string nm);
        int n = 0;
        while (dut.state_q !== s && n < 200) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (dut.state_q !== s) begin
            tests_failed++;
            $display("FAIL %s: state=%0d required=%0d (timeout)", nm, dut.state_q, s);
        end
    endtask

    task automatic pulse_we(input logic [7:0] d);
        cpu_if.cpu_out_we   = 1'b1;
        cpu_if.cpu_out_data = d;
        tick(1);
        cpu_if.cpu_out_we   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; sw_handshake = 1'b1; sw_data = 8'h55;
        cpu_if.cpu_in_sel = 1'b0; cpu_if.cpu_out_we = 1'b0; cpu_if.cpu_out_data = 8'h00;
        tick(4);
        tests_run++; if (dut.state_q !== ARM) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ARM); end
        tests_run++; if (led !== 8'h00) begin tests_failed++; $display("FAIL reset_led: got %h want 00", led); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (cpu_if.cpu_run !== 1'b0 || cpu_if.cpu_start !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu: run=%b start=%b want 0 0", cpu_if.cpu_run, cpu_if.cpu_start); end
        reset = 1'b0;
        tick(LAT + 10);
        tests_run++; if (dut.state_q !== ARM) begin tests_failed++; $display("FAIL arm_hold: got %0d want %0d", dut.state_q, ARM); end
        tests_run++; if (dut.in_buf_q[0] !== 8'h00) begin tests_failed++; $display("FAIL arm_nocapture: got %h want 00", dut.in_buf_q[0]); end
        sw_handshake = 1'b0;
        wait_state(IN_HI, "arm_release");
        tests_run++; if (led !== 8'h00 || dut.in_buf_q[0] !== 8'h00) begin tests_failed++; $display("FAIL arm_release_clean: led=%h buf0=%h want 00 00", led, dut.in_buf_q[0]); end
        $display("[TB] reset/arm sequence done");
    endtask

    task automatic test_capture;
        sw_data = 8'd8; sw_handshake = 1'b1;
        tick(LAT - 1);
        tests_run++; if (dut.in_buf_q[0] !== 8'h00) begin tests_failed++; $display("FAIL cap0_early: got %h want 00", dut.in_buf_q[0]); end
        tick(1);
        tests_run++; if (dut.in_buf_q[0] !== 8'd8 || dut.state_q !== IN_LO) begin tests_failed++; $display("FAIL cap0: buf0=%0d state=%0d want 8 %0d", dut.in_buf_q[0], dut.state_q, IN_LO); end
        sw_handshake = 1'b0;
        tick(LAT);
        tests_run++; if (dut.state_q !== IN_HI || dut.ii_q !== 1'b1) begin tests_failed++; $display("FAIL fall0: state=%0d ii=%0d want %0d 1", dut.state_q, dut.ii_q, IN_HI); end
        sw_data = 8'd16; sw_handshake = 1'b1;
        tick(LAT);
        tests_run++; if (dut.in_buf_q[1] !== 8'd16) begin tests_failed++; $display("FAIL cap1: got %0d want 16", dut.in_buf_q[1]); end
        sw_handshake = 1'b0;
        tick(LAT - 1);
        tests_run++; if (cpu_if.cpu_run !== 1'b0 || cpu_if.cpu_start !== 1'b0) begin tests_failed++; $display("FAIL start_early: run=%b start=%b want 0 0", cpu_if.cpu_run, cpu_if.cpu_start); end
        tick(1);
        tests_run++; if (cpu_if.cpu_run !== 1'b1 || cpu_if.cpu_start !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL start: run=%b start=%b busy=%b want 1 1 1", cpu_if.cpu_run, cpu_if.cpu_start, busy); end
        tick(1);
        tests_run++; if (cpu_if.cpu_start !== 1'b0 || cpu_if.cpu_run !== 1'b1) begin tests_failed++; $display("FAIL start_once: start=%b run=%b want 0 1", cpu_if.cpu_start, cpu_if.cpu_run); end
        cpu_if.cpu_in_sel = 1'b0; #1;
        tests_run++; if (cpu_if.cpu_in_data !== 8'd8) begin tests_failed++; $display("FAIL in_data0: got %0d want 8", cpu_if.cpu_in_data); end
        cpu_if.cpu_in_sel = 1'b1; #1;
        tests_run++; if (cpu_if.cpu_in_data !== 8'd16) begin tests_failed++; $display("FAIL in_data1: got %0d want 16", cpu_if.cpu_in_data); end
        $display("[TB] operands 8,16 captured, core started");
    endtask

    task automatic test_run_show;
        pulse_we(8'h18);
        tests_run++; if (dut.out_buf_q[0] !== 8'h18 || led !== 8'h00 || dut.state_q !== RUN) begin tests_failed++; $display("FAIL wr0: buf0=%h led=%h state=%0d want 18 00 %0d", dut.out_buf_q[0], led, dut.state_q, RUN); end
        pulse_we(8'h80);
        tests_run++; if (led !== 8'h18 || dut.state_q !== SHOW) begin tests_failed++; $display("FAIL wr1_led: led=%h state=%0d want 18 %0d", led, dut.state_q, SHOW); end
        pulse_we(8'hEE);
        tests_run++; if (dut.out_buf_q[0] !== 8'h18 || dut.out_buf_q[1] !== 8'h80 || led !== 8'h18) begin tests_failed++; $display("FAIL we_in_show: buf=%h,%h led=%h want 18,80 18", dut.out_buf_q[0], dut.out_buf_q[1], led); end
        sw_handshake = 1'b1;
        tick(LAT - 1);
        tests_run++; if (led !== 8'h18) begin tests_failed++; $display("FAIL show_early: led=%h want 18", led); end
        tick(1);
        tests_run++; if (led !== 8'h80) begin tests_failed++; $display("FAIL show_rise: led=%h want 80", led); end
        sw_handshake = 1'b0;
        tick(LAT);
        tests_run++; if (dut.state_q !== ARM || led !== 8'h80) begin tests_failed++; $display("FAIL show_fall: state=%0d led=%h want %0d 80", dut.state_q, led, ARM); end
        wait_state(IN_HI, "rearm");
        pulse_we(8'h77);
        tests_run++; if (dut.out_buf_q[0] !== 8'h18 || dut.out_buf_q[1] !== 8'h80 || led !== 8'h80) begin tests_failed++; $display("FAIL we_in_in_hi: buf=%h,%h led=%h want 18,80 80", dut.out_buf_q[0], dut.out_buf_q[1], led); end
        $display("[TB] results 18,80 shown");
    endtask

    task automatic test_reset_mid;
        sw_data = 8'h5A; sw_handshake = 1'b1;
        tick(LAT);
        tests_run++; if (dut.in_buf_q[0] !== 8'h5A) begin tests_failed++; $display("FAIL mid_cap: got %h want 5a", dut.in_buf_q[0]); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests_run++; if (dut.state_q !== ARM || dut.in_buf_q[0] !== 8'h00 || led !== 8'h00 || dut.out_buf_q[1] !== 8'h00) begin tests_failed++; $display("FAIL mid_reset: state=%0d buf0=%h led=%h obuf1=%h want %0d 00 00 00", dut.state_q, dut.in_buf_q[0], led, dut.out_buf_q[1], ARM); end
        tick(LAT + 6);
        tests_run++; if (dut.state_q !== ARM) begin tests_failed++; $display("FAIL mid_arm_hold: state=%0d want %0d", dut.state_q, ARM); end
        sw_handshake = 1'b0;
        wait_state(IN_HI, "mid_rearm");
        $display("[TB] mid-transaction reset done");
    endtask

    task automatic test_back_to_back;
        sw_data = 8'h03; sw_handshake = 1'b1; tick(LAT);
        sw_handshake = 1'b0; tick(LAT);
        sw_data = 8'h04; sw_handshake = 1'b1; tick(LAT);
        sw_handshake = 1'b0; tick(LAT);
        tests_run++; if (dut.in_buf_q[0] !== 8'h03 || dut.in_buf_q[1] !== 8'h04 || cpu_if.cpu_start !== 1'b1) begin tests_failed++; $display("FAIL b2b_in: buf=%h,%h start=%b want 03,04 1", dut.in_buf_q[0], dut.in_buf_q[1], cpu_if.cpu_start); end
        pulse_we(8'h11);
        pulse_we(8'h22);
        tests_run++; if (led !== 8'h11) begin tests_failed++; $display("FAIL b2b_led0: led=%h want 11", led); end
        sw_handshake = 1'b1; tick(LAT);
        tests_run++; if (led !== 8'h22) begin tests_failed++; $display("FAIL b2b_led1: led=%h want 22", led); end
        sw_handshake = 1'b0; tick(LAT);
        tests_run++; if (dut.state_q !== ARM) begin tests_failed++; $display("FAIL b2b_end: state=%0d want %0d", dut.state_q, ARM); end
        wait_state(IN_HI, "b2b_rearm");
        $display("[TB] transaction 03,04 -> 11,22 done");
    endtask

    task automatic test_glitch;
        logic [7:0] exp_buf;
        logic       exp_ii;
`ifdef PICOMIPS_HS_DEBOUNCE_EN
        exp_buf = 8'h03; exp_ii = 1'b0;
`else
        exp_buf = 8'h33; exp_ii = 1'b1;
`endif
        sw_data = 8'h33; sw_handshake = 1'b1;
        tick(1);
        sw_handshake = 1'b0;
        tick(LAT + 6);
        tests_run++; if (dut.in_buf_q[0] !== exp_buf) begin tests_failed++; $display("FAIL glitch_buf: got %h want %h", dut.in_buf_q[0], exp_buf); end
        tests_run++; if (dut.ii_q !== exp_ii || dut.state_q !== IN_HI) begin tests_failed++; $display("FAIL glitch_state: ii=%0d state=%0d want %0d %0d", dut.ii_q, dut.state_q, exp_ii, IN_HI); end
        $display("[TB] one-cycle handshake glitch done");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_run_show();
        test_reset_mid();
        test_back_to_back();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
